prod_to_bcd: RTL and testbench

Sequential binary-to-BCD converter (shift-add-3 / double-dabble) placed directly downstream of SeqMultiplier. It consumes the 16-bit product C and produces packed BCD digits for the 7-segment and UART display stages. It converts one bit per cycle and uses a start/busy/done handshake, so the multiplier result can be handed over once it is stable.

---
 rtl/prod_to_bcd_pkg.sv | 36 +++
 rtl/prod_to_bcd_add3.sv | 15 +
 rtl/prod_to_bcd.sv | 117 +++++++++++
 tb/tb_prod_to_bcd.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/prod_to_bcd_pkg.sv
// Shared types and constants for the binary-to-BCD converter.
// Helper functions size the counter and check digit capacity.
package prod_to_bcd_pkg;

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

  localparam int IN_W_DEF   = 16;
  localparam int DIGITS_DEF = 5;
  localparam int CNT_W_DEF  = $clog2(IN_W_DEF + 1);

  localparam logic [7:0] ASCII_ZERO  = 8'h30;
  localparam logic [7:0] ASCII_SPACE = 8'h20;

  function automatic int cnt_w(input int in_w);
    return $clog2(in_w + 1);
  endfunction

  // True when DIGITS decimal digits can hold 2^in_w - 1.
  function automatic bit digits_fit(
    input int in_w,
    input int digits
  );
    longint unsigned p;
    longint unsigned mx;
    p  = 1;
    mx = (64'd1 << in_w) - 64'd1;
    for (int i = 0; i < digits; i++) begin
      p = p * 10;
    end
    return p > mx;
  endfunction

endpackage

// File: rtl/prod_to_bcd_add3.sv
// Double-dabble digit adjust: add 3 to any digit of 5 or more.
// The input is always <= 9, so the 4-bit sum cannot overflow.
module bcd_add3 (
  input  logic [3:0] d,
  output logic [3:0] q
);

  always_comb begin
    q = d;
    if (d >= 4'd5) begin
      q = d + 4'd3;
    end
  end

endmodule

// File: rtl/prod_to_bcd.sv
// Sequential shift-add-3 binary to packed BCD converter.
// Optional ascii output enabled by macro PROD2BCD_ASCII_EN.
module prod_to_bcd
  import prod_to_bcd_pkg::*;
#(
  parameter int IN_W   = IN_W_DEF,
  parameter int DIGITS = DIGITS_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [IN_W-1:0]     bin,
  output logic                busy,
  output logic                done,
  output logic [4*DIGITS-1:0] bcd
`ifdef PROD2BCD_ASCII_EN
  ,
  output logic [8*DIGITS-1:0] ascii
`endif
);

  localparam int CNT_W = cnt_w(IN_W);
  localparam int BW    = 4 * DIGITS;

  if (!digits_fit(IN_W, DIGITS)) begin : g_bad_digits
    $error("prod_to_bcd: DIGITS too small for IN_W");
  end

  state_t           state;
  logic [IN_W-1:0]  shreg;
  logic [BW-1:0]    scratch;
  logic [CNT_W-1:0] cnt;

  logic [BW-1:0]    adj;
  logic [BW-1:0]    shifted;

  for (genvar i = 0; i < DIGITS; i++) begin : g_adj
    bcd_add3 u_add3 (
      .d (scratch[4*i +: 4]),
      .q (adj[4*i +: 4])
    );
  end

  assign shifted = (adj << 1)
                 | {{(BW-1){1'b0}}, shreg[IN_W-1]};

`ifdef PROD2BCD_ASCII_EN
  localparam logic [8*DIGITS-1:0] ASCII_RST =
    {{(DIGITS-1){ASCII_SPACE}}, ASCII_ZERO};

  logic [8*DIGITS-1:0] ascii_nx;
  logic                lead;
  logic [3:0]          dg;

  // Blank leading zeros; digit 0 is always shown.
  always_comb begin
    ascii_nx = '0;
    lead     = 1'b1;
    dg       = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      dg = shifted[4*i +: 4];
      if (i != 0 && lead && dg == 4'd0) begin
        ascii_nx[8*i +: 8] = ASCII_SPACE;
      end else begin
        ascii_nx[8*i +: 8] = ASCII_ZERO + {4'd0, dg};
        lead = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ascii <= ASCII_RST;
    end else if (state == SHIFT && cnt == CNT_W'(1)) begin
      ascii <= ascii_nx;
    end
  end
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      bcd     <= '0;
      shreg   <= '0;
      scratch <= '0;
      cnt     <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            shreg   <= bin;
            scratch <= '0;
            cnt     <= CNT_W'(IN_W);
            busy    <= 1'b1;
            state   <= SHIFT;
          end
        end
        SHIFT: begin
          scratch <= shifted;
          shreg   <= shreg << 1;
          cnt     <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) begin
            bcd   <= shifted;
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_prod_to_bcd.sv
// Directed bench for prod_to_bcd with hand-computed BCD results.
// ascii checks are active when PROD2BCD_ASCII_EN is defined.
module tb_prod_to_bcd;

  logic        clk;
  logic        reset;
  logic        start;
  logic [15:0] bin;
  logic        busy;
  logic        done;
  logic [19:0] bcd;
`ifdef PROD2BCD_ASCII_EN
  logic [39:0] ascii;
`endif

  int n_chk;
  int n_pass;

  prod_to_bcd dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .bin   (bin),
    .busy  (busy),
    .done  (done),
    .bcd   (bcd)
`ifdef PROD2BCD_ASCII_EN
    ,
    .ascii (ascii)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(
    input string       tag,
    input logic [63:0] got,
    input logic [63:0] exp
  );
    n_chk++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic run(
    input  logic [15:0] v,
    input  int          inj,
    input  logic [15:0] inj_v,
    output int          lat,
    output int          ndone,
    output bit          moved
  );
    logic [19:0] prev;
    @(negedge clk);
    bin   = v;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    prev  = bcd;
    lat   = 0;
    ndone = 0;
    moved = 1'b0;
    chk("busy_on", {63'd0, busy}, 64'd1);
    for (int k = 1; k <= 20; k++) begin
      if (k == inj) begin
        start = 1'b1;
        bin   = inj_v;
      end
      @(posedge clk);
      #1;
      start = 1'b0;
      if (done) begin
        ndone++;
        if (lat == 0) lat = k;
      end else if (lat == 0 && bcd !== prev) begin
        moved = 1'b1;
      end
    end
  endtask

  task automatic conv(
    input string       tag,
    input logic [15:0] v,
    input logic [19:0] exp,
    input int          inj,
    input logic [15:0] inj_v
  );
    int lat;
    int nd;
    bit mv;
    run(v, inj, inj_v, lat, nd, mv);
    chk({tag, "_lat"}, 64'(lat), 64'd16);
    chk({tag, "_ndone"}, 64'(nd), 64'd1);
    chk({tag, "_held"}, {63'd0, mv}, 64'd0);
    chk({tag, "_bcd"}, {44'd0, bcd}, {44'd0, exp});
    chk({tag, "_idle"}, {63'd0, busy}, 64'd0);
  endtask

  initial begin
    int t1;
    int t2;
    int nd;
    n_chk  = 0;
    n_pass = 0;
    reset  = 1'b1;
    start  = 1'b0;
    bin    = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_done", {63'd0, done}, 64'd0);
    chk("rst_bcd", {44'd0, bcd}, 64'd0);
`ifdef PROD2BCD_ASCII_EN
    chk("rst_ascii", {24'd0, ascii}, 64'h20_2020_2030);
`endif
    @(negedge clk);
    reset = 1'b0;

    conv("c38957", 16'd38957, 20'h38957, 0, '0);
`ifdef PROD2BCD_ASCII_EN
    chk("ascii_38957", {24'd0, ascii}, 64'h33_3839_3537);
`endif
    conv("c0", 16'd0, 20'h00000, 0, '0);
    conv("cffff", 16'hFFFF, 20'h65535, 0, '0);
    conv("c9", 16'd9, 20'h00009, 0, '0);
    conv("ign", 16'd38957, 20'h38957, 5, 16'd123);

    // Back-to-back with start held high.
    @(negedge clk);
    bin   = 16'd100;
    start = 1'b1;
    @(posedge clk);
    #1;
    bin = 16'd200;
    t1  = 0;
    t2  = 0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk);
      #1;
      if (done) begin
        if (t1 == 0) begin
          t1 = k;
          chk("b2b_bcd1", {44'd0, bcd}, 64'h100);
        end else if (t2 == 0) begin
          t2 = k;
          chk("b2b_bcd2", {44'd0, bcd}, 64'h200);
          start = 1'b0;
        end
      end
    end
    start = 1'b0;
    chk("b2b_t1", 64'(t1), 64'd16);
    chk("b2b_gap", 64'(t2 - t1), 64'd17);
    repeat (20) @(posedge clk);

    // Reset in the middle of a conversion.
    conv("pre", 16'd9, 20'h00009, 0, '0);
    @(negedge clk);
    bin   = 16'd38957;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    chk("abort_busy", {63'd0, busy}, 64'd0);
    chk("abort_bcd", {44'd0, bcd}, 64'd0);
    chk("abort_done", {63'd0, done}, 64'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    nd    = 0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk);
      #1;
      if (done) nd++;
    end
    chk("abort_nodone", 64'(nd), 64'd0);
    conv("c42", 16'd42, 20'h00042, 0, '0);
`ifdef PROD2BCD_ASCII_EN
    chk("ascii_42", {24'd0, ascii}, 64'h20_2020_3432);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
